// File: rtl/sm3_padded_hasher.sv
// rtl/sm3_padded_hasher.sv - SM3 digest of a fixed-length message: pads, then chains one CF core over all blocks.
module sm3_padded_hasher #(
  parameter int          MSG_BITS = 1792,
  parameter logic [255:0] IV_INIT = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_BITS-1:0] msg,
  output logic                busy,
  output logic                done,
  output logic [255:0]        digest
);
  localparam int NBLK      = (MSG_BITS + 64) / 512 + 1;
  localparam int PAD_BITS  = NBLK * 512;
  localparam int ZERO_BITS = PAD_BITS - MSG_BITS - 65;
  localparam int CW        = $clog2(NBLK) + 1;
  localparam logic [63:0] LEN = 64'(MSG_BITS);

  generate
    if (MSG_BITS < 8 || MSG_BITS > 4096 || (MSG_BITS % 8) != 0) begin : g_bad_msg_bits
      $fatal(1, "MSG_BITS must be a multiple of 8 in 8..4096");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FINAL} state_t;

  state_t                state;
  logic [PAD_BITS-1:0]   padded;
  logic [CW-1:0]         blk_cnt;
  logic [255:0]          chain_iv;
  logic                  cf_start;
  logic                  cf_end;
  logic [255:0]          cf_hash;
  logic [511:0]          cf_block;

  // blk_cnt and chain_iv only move on cf_end, so block and iv stay stable for the whole CF run
  always_comb begin
    cf_block = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (blk_cnt == CW'(k)) cf_block = padded[PAD_BITS-1-512*k -: 512];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      digest   <= '0;
      cf_start <= 1'b0;
      blk_cnt  <= '0;
      chain_iv <= IV_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // a start coinciding with the done pulse is not a new request
          if (start && !done) begin
            padded   <= {msg, 1'b1, {ZERO_BITS{1'b0}}, LEN};
            blk_cnt  <= '0;
            chain_iv <= IV_INIT;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          cf_start <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (cf_end) begin
            cf_start <= 1'b0;
            chain_iv <= cf_hash;
            if (blk_cnt == CW'(NBLK - 1)) begin
              state <= FINAL;
            end else begin
              blk_cnt <= blk_cnt + 1'b1;
              state   <= LOAD;
            end
          end
        end
        FINAL: begin
          digest <= chain_iv;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sm3_CF u_cf (
    .clk      (clk),
    .reset    (reset),
    .start    (cf_start),
    .iv       (chain_iv),
    .block    (cf_block),
    .hash     (cf_hash),
    .hash_end (cf_end)
  );
endmodule

// SM3 compression function, one round per cycle; hash_end pulses once per run and the core
// re-arms only after start has been seen low.
module sm3_CF (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] iv,
  input  logic [511:0] block,
  output logic [255:0] hash,
  output logic         hash_end
);
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_END} cstate_t;

  cstate_t     cstate;
  logic [5:0]  rnd;
  logic [31:0] wk [8];
  logic [31:0] vs [8];
  logic [31:0] w [16];
  logic [31:0] nxt [8];
  logic [31:0] tj, ss1, ss2, tt1, tt2, ff, gg, w_new;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // w holds the sliding window W[j..j+15]; W'[j] is w[0]^w[4]
  always_comb begin
    tj  = (rnd < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
    ss1 = rotl(rotl(wk[0], 12) + wk[4] + rotl(tj, int'(rnd[4:0])), 7);
    ss2 = ss1 ^ rotl(wk[0], 12);
    if (rnd < 6'd16) begin
      ff = wk[0] ^ wk[1] ^ wk[2];
      gg = wk[4] ^ wk[5] ^ wk[6];
    end else begin
      ff = (wk[0] & wk[1]) | (wk[0] & wk[2]) | (wk[1] & wk[2]);
      gg = (wk[4] & wk[5]) | (~wk[4] & wk[6]);
    end
    tt1    = ff + wk[3] + ss2 + (w[0] ^ w[4]);
    tt2    = gg + wk[7] + ss1 + w[0];
    nxt[0] = tt1;
    nxt[1] = wk[0];
    nxt[2] = rotl(wk[1], 9);
    nxt[3] = wk[2];
    nxt[4] = p0(tt2);
    nxt[5] = wk[4];
    nxt[6] = rotl(wk[5], 19);
    nxt[7] = wk[6];
    w_new  = p1(w[0] ^ w[7] ^ rotl(w[13], 15)) ^ rotl(w[3], 7) ^ w[10];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cstate   <= C_IDLE;
      rnd      <= '0;
      hash     <= '0;
      hash_end <= 1'b0;
    end else begin
      case (cstate)
        C_IDLE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              wk[i] <= iv[255-32*i -: 32];
              vs[i] <= iv[255-32*i -: 32];
            end
            for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
            rnd    <= '0;
            cstate <= C_RUN;
          end
        end
        C_RUN: begin
          for (int i = 0; i < 8; i++) wk[i] <= nxt[i];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          if (rnd == 6'd63) begin
            for (int i = 0; i < 8; i++) hash[255-32*i -: 32] <= nxt[i] ^ vs[i];
            hash_end <= 1'b1;
            cstate   <= C_END;
          end else begin
            rnd <= rnd + 6'd1;
          end
        end
        C_END: begin
          hash_end <= 1'b0;
          if (!start) cstate <= C_IDLE;
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm3_padded_hasher.sv
// tb/tb_sm3_padded_hasher.sv - scoreboard bench for sm3_padded_hasher at 24, 512 and 1792 message bits.
module tb_sm3_padded_hasher;
  localparam logic [255:0] ABC  = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] ABCD = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_a, start_b, start_c;
  logic [23:0]   msg_a;
  logic [511:0]  msg_b;
  logic [1791:0] msg_c;
  logic          busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [255:0]  dig_a, dig_b, dig_c;

  sm3_padded_hasher #(.MSG_BITS(24)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .msg(msg_a), .busy(busy_a), .done(done_a), .digest(dig_a));
  sm3_padded_hasher #(.MSG_BITS(512)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .msg(msg_b), .busy(busy_b), .done(done_b), .digest(dig_b));
  sm3_padded_hasher #(.MSG_BITS(1792)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .msg(msg_c), .busy(busy_c), .done(done_c), .digest(dig_c));

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] q_a[$], q_b[$], q_c[$];
  int rises_b = 0, rises_c = 0;
  logic prev_b = 1'b0, prev_c = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int s = n % 32;
    return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
  endfunction

  function automatic logic [31:0] pp0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] pp1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Textbook SM3 over a byte list: pad, expand all 68 words, compress block by block
  function automatic logic [255:0] sm3_ref(input logic [4095:0] m, input int nbits);
    byte unsigned by[$];
    logic [255:0] iv = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
    logic [31:0] v[8], r[8], w[68], wp[64];
    logic [31:0] tj, ss1, ss2, tt1, tt2, ff, gg;
    longint len = nbits;
    for (int i = 0; i < nbits / 8; i++) by.push_back(m[nbits-1-8*i -: 8]);
    by.push_back(8'h80);
    while (by.size() % 64 != 56) by.push_back(8'h00);
    for (int i = 7; i >= 0; i--) by.push_back(8'(len >> (8 * i)));
    for (int i = 0; i < 8; i++) v[i] = iv[255-32*i -: 32];
    for (int b = 0; b < by.size() / 64; b++) begin
      for (int j = 0; j < 16; j++)
        w[j] = {by[64*b+4*j], by[64*b+4*j+1], by[64*b+4*j+2], by[64*b+4*j+3]};
      for (int j = 16; j < 68; j++)
        w[j] = pp1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
      for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
      r = v;
      for (int j = 0; j < 64; j++) begin
        tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
        ss1 = rl(rl(r[0], 12) + r[4] + rl(tj, j), 7);
        ss2 = ss1 ^ rl(r[0], 12);
        ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
        gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
        tt1 = ff + r[3] + ss2 + wp[j];
        tt2 = gg + r[7] + ss1 + w[j];
        r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
        r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = pp0(tt2);
      end
      for (int i = 0; i < 8; i++) v[i] = v[i] ^ r[i];
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && done_a === 1'b1) begin
      if (q_a.size() == 0) begin n_cmp++; n_bad++; $display("FAIL unexpected_done_a: got done=1 required no done"); end
      else check("digest_a", dig_a, q_a.pop_front());
    end
  end
  always @(negedge clk) begin
    if (reset === 1'b1 && done_b === 1'b1) begin
      if (q_b.size() == 0) begin n_cmp++; n_bad++; $display("FAIL unexpected_done_b: got done=1 required no done"); end
      else check("digest_b", dig_b, q_b.pop_front());
    end
  end
  always @(negedge clk) begin
    if (reset === 1'b1 && done_c === 1'b1) begin
      if (q_c.size() == 0) begin n_cmp++; n_bad++; $display("FAIL unexpected_done_c: got done=1 required no done"); end
      else check("digest_c", dig_c, q_c.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dut_b.cf_start && !prev_b) rises_b <= rises_b + 1;
    if (dut_c.cf_start && !prev_c) rises_c <= rises_c + 1;
    prev_b <= dut_b.cf_start;
    prev_c <= dut_c.cf_start;
  end

  // Presents one start pulse to an idle DUT, queues the expected digest, then scrambles msg
  task automatic issue(input int sel, input logic [4095:0] m, input logic [255:0] exp);
    @(negedge clk);
    case (sel)
      0: begin start_a = 1'b1; msg_a = m[23:0];   q_a.push_back(exp); end
      1: begin start_b = 1'b1; msg_b = m[511:0];  q_b.push_back(exp); end
      default: begin start_c = 1'b1; msg_c = m[1791:0]; q_c.push_back(exp); end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    msg_a = ~msg_a;
    msg_b = ~msg_b ^ {16{32'($urandom)}};
    msg_c = ~msg_c ^ {56{32'($urandom)}};
  endtask

  task automatic wait_done(input int sel, input string nm);
    int k;
    logic d;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      if (d === 1'b1) break;
    end
    if (k == 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done in 3000 cycles required done=1", nm);
    end
  endtask

  function automatic logic [4095:0] rand_msg(input int nbits);
    logic [4095:0] m = '0;
    for (int i = 0; i < nbits / 32; i++) m[32*i +: 32] = $urandom;
    if (nbits == 24) m[31:24] = 8'h00;
    return m;
  endfunction

  initial begin
    logic [4095:0] m;
    logic [511:0]  t512;
    int r0, k;

    reset = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    msg_a = '0; msg_b = '0; msg_c = '0;
    repeat (3) @(negedge clk);
    check("reset_busy_a", 256'(busy_a), 0);
    check("reset_done_a", 256'(done_a), 0);
    check("reset_digest_a", dig_a, 0);
    check("reset_busy_c", 256'(busy_c), 0);
    check("reset_done_c", 256'(done_c), 0);
    check("reset_digest_c", dig_c, 0);
    check("reset_digest_b", dig_b, 0);
    reset = 1'b1;
    @(negedge clk);

    m = '0; m[23:0] = 24'h616263;
    issue(0, m, ABC);
    check("busy_after_accept_a", 256'(busy_a), 1);
    wait_done(0, "abc");

    t512 = {16{"abcd"}};
    m = '0; m[511:0] = t512;
    r0 = rises_b;
    issue(1, m, ABCD);
    wait_done(1, "abcd");
    @(negedge clk);
    check("cf_runs_512", 256'(rises_b - r0), 2);

    for (int i = 0; i < 4; i++) begin
      m = rand_msg(24);
      issue(0, m, sm3_ref(m, 24));
      wait_done(0, "rand_a");
    end
    for (int i = 0; i < 2; i++) begin
      m = rand_msg(512);
      issue(1, m, sm3_ref(m, 512));
      wait_done(1, "rand_b");
    end
    for (int i = 0; i < 2; i++) begin
      m = rand_msg(1792);
      r0 = rises_c;
      issue(2, m, sm3_ref(m, 1792));
      wait_done(2, "rand_c");
      @(negedge clk);
      check("cf_runs_1792", 256'(rises_c - r0), 4);
    end

    // start held high and msg churned every cycle through the whole run and the done cycle
    m = rand_msg(1792);
    @(negedge clk);
    start_c = 1'b1; msg_c = m[1791:0]; q_c.push_back(sm3_ref(m, 1792));
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      msg_c = msg_c ^ {56{32'($urandom)}};
      if (done_c === 1'b1) break;
    end
    if (k == 3000) begin n_cmp++; n_bad++; $display("FAIL spam_timeout: got no done required done=1"); end
    @(negedge clk);
    check("start_in_done_cycle_busy", 256'(busy_c), 0);
    start_c = 1'b0;
    repeat (5) @(negedge clk);
    check("no_restart_busy", 256'(busy_c), 0);

    // abort in the middle of block 2, then rerun the same message
    m = rand_msg(1792);
    r0 = rises_c;
    issue(2, m, sm3_ref(m, 1792));
    for (k = 0; k < 3000 && (rises_c - r0) < 3; k++) @(negedge clk);
    if (k == 3000) begin n_cmp++; n_bad++; $display("FAIL block2_timeout: got %0d cf runs required 3", rises_c - r0); end
    repeat (10) @(negedge clk);
    reset = 1'b0;
    q_c.delete();
    repeat (2) @(negedge clk);
    check("abort_busy_c", 256'(busy_c), 0);
    check("abort_done_c", 256'(done_c), 0);
    check("abort_digest_c", dig_c, 0);
    check("abort_cf_start_c", 256'(dut_c.cf_start), 0);
    check("abort_digest_a", dig_a, 0);
    reset = 1'b1;
    repeat (400) @(negedge clk);
    check("abort_no_done_busy_c", 256'(busy_c), 0);
    check("abort_digest_c_held", dig_c, 0);
    issue(2, m, sm3_ref(m, 1792));
    wait_done(2, "rerun_c");
    m = '0; m[23:0] = 24'h616263;
    issue(0, m, ABC);
    wait_done(0, "abc_again");

    repeat (5) @(negedge clk);
    check("drained_a", 256'(q_a.size()), 0);
    check("drained_b", 256'(q_b.size()), 0);
    check("drained_c", 256'(q_c.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
